// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and helpers for the tiled GEMM sequencer.
//   sched_state_e  - scheduler FSM states
//   ceil_div       - integer ceiling division used for tile counts
//   accum_rows     - accumulator rows available per column tile
//   fill_repeats   - number of SYS_ROW blocks that fit in the weight FIFO
//   idx_width      - safe index width (never 0)
package gemm_pkg;

  localparam int unsigned DEF_SYS_ROW    = 16;
  localparam int unsigned DEF_SYS_COL    = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_ACCUM_SIZE = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_INIT_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } sched_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    int unsigned q;
    q = num / den;
    if ((num % den) != 0) q = q + 1;
    return q;
  endfunction

  function automatic int unsigned accum_rows(input int unsigned accum_size, input int unsigned sys_col);
    return accum_size / sys_col;
  endfunction

  function automatic int unsigned fill_repeats(input int unsigned fifo_depth, input int unsigned sys_row);
    return fifo_depth / sys_row;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_store_gen.sv
// tile_store_gen: walks accumulator rows 0..last_row for one column tile and
// produces the matching output address, one beat per valid/ready transfer.
// The output address starts at base_i and advances by stride_i per accepted
// beat, so no multiplier is needed.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   start_i        - pulse: begin a new tile (row 0, address base_i)
//   last_row_i     - index of the final row of the tile
//   base_i         - first output address (column tile index)
//   stride_i       - address step per row (number of column tiles)
//   ready_i        - consumer ready
//   valid_o        - beat available; row_o/addr_o held until accepted
//   last_o         - pulse: the final beat was accepted this cycle
module tile_store_gen
  import gemm_pkg::*;
#(
  parameter int unsigned ROW_W      = 5,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ROW_W-1:0]      last_row_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [ROW_W-1:0]      row_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fire;
  logic                  at_last;

  assign fire    = valid_q & ready_i;
  assign at_last = (row_q == last_row_i);

  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    addr_d  = addr_q;
    if (start_i) begin
      valid_d = 1'b1;
      row_d   = '0;
      addr_d  = base_i;
    end else if (fire) begin
      if (at_last) begin
        valid_d = 1'b0;
      end else begin
        row_d  = row_q + ROW_W'(1);
        addr_d = addr_q + stride_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign row_o   = row_q;
  assign addr_o  = addr_q;
  assign last_o  = fire & at_last;

endmodule

// File: rtl/gemm_tile_sched.sv
// gemm_tile_sched: master sequencer for the tiled GEMM datapath.
// Accepts a (num_in x num_common) * (num_common x num_out) job, fills the
// weight FIFO, issues one compute command per K-tile, and stores each column
// tile from the accumulator before moving to the next.
//   clk_i, rst_i                  - clock, synchronous active-high reset
//   start_i, num_*_i, relu_en_i   - job request and dimensions
//   busy_o, done_o, err_o         - job status
//   fill_req_o/base/repeat, fill_done_i            - weight FIFO fill
//   comp_req_o/w_base/in_base/weight_fill, sys_done_i - per-tile compute
//   w_invalid_o                   - weight invalidate after each tile
//   store_valid_o/ready_i/accum_addr/out_addr/relu - store beats
//   accum_clr_o                   - accumulator clear after a column tile
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for start
// CHECK      | compute tile counts, validate job
// INIT_FILL  | fill_req on entry, then wait for fill_done
// ISSUE      | comp_req for current K-tile
// WAIT       | wait for sys_done; next K-tile or store
// STORE      | store beats; one extra cycle carries accum_clr
// DONE       | done pulse (err when rejected)
module gemm_tile_sched
  import gemm_pkg::*;
#(
  parameter int unsigned SYS_ROW    = DEF_SYS_ROW,
  parameter int unsigned SYS_COL    = DEF_SYS_COL,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned ACCUM_SIZE = DEF_ACCUM_SIZE,
  parameter int unsigned FIFO_DEPTH = 2 * SYS_ROW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] num_in_i,
  input  logic [DATA_WIDTH-1:0] num_common_i,
  input  logic [DATA_WIDTH-1:0] num_out_i,
  input  logic                  relu_en_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  fill_req_o,
  output logic [ADDR_WIDTH-1:0] fill_base_o,
  output logic [31:0]           fill_repeat_o,
  input  logic                  fill_done_i,
  output logic                  comp_req_o,
  output logic [ADDR_WIDTH-1:0] comp_w_base_o,
  output logic [ADDR_WIDTH-1:0] comp_in_base_o,
  output logic                  comp_weight_fill_o,
  input  logic                  sys_done_i,
  output logic [SYS_ROW-1:0]    w_invalid_o,
  output logic                  store_valid_o,
  input  logic                  store_ready_i,
  output logic [idx_width(accum_rows(ACCUM_SIZE, SYS_COL))-1:0] store_accum_addr_o,
  output logic [ADDR_WIDTH-1:0] store_out_addr_o,
  output logic                  store_relu_o,
  output logic                  accum_clr_o
);

  localparam int unsigned ACCUM_ROW   = accum_rows(ACCUM_SIZE, SYS_COL);
  localparam int unsigned FILL_REPEAT = fill_repeats(FIFO_DEPTH, SYS_ROW);
  localparam int unsigned ROW_W       = idx_width(ACCUM_ROW);

  sched_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] num_in_q, num_in_d;
  logic [DATA_WIDTH-1:0] num_common_q, num_common_d;
  logic [DATA_WIDTH-1:0] num_out_q, num_out_d;
  logic                  relu_q, relu_d;
  logic [DATA_WIDTH-1:0] tiles_k_q, tiles_k_d;
  logic [DATA_WIDTH-1:0] tiles_n_q, tiles_n_d;
  logic [DATA_WIDTH-1:0] kt_q, kt_d;
  logic [DATA_WIDTH-1:0] nt_q, nt_d;
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic                  first_q, first_d;
  logic                  fill_sent_q, fill_sent_d;
  logic                  err_q, err_d;
  logic                  w_inv_q, w_inv_d;
  logic                  accum_clr_q, accum_clr_d;

  logic                  store_start;
  logic                  store_last;
  logic                  job_bad;

  assign job_bad = (num_in_q == '0) || (num_common_q == '0) || (num_out_q == '0) ||
                   (32'(num_in_q) > ACCUM_ROW);

  always_comb begin
    state_d      = state_q;
    num_in_d     = num_in_q;
    num_common_d = num_common_q;
    num_out_d    = num_out_q;
    relu_d       = relu_q;
    tiles_k_d    = tiles_k_q;
    tiles_n_d    = tiles_n_q;
    kt_d         = kt_q;
    nt_d         = nt_q;
    w_ptr_d      = w_ptr_q;
    first_d      = first_q;
    fill_sent_d  = fill_sent_q;
    err_d        = err_q;
    w_inv_d      = 1'b0;
    accum_clr_d  = 1'b0;
    store_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          num_in_d     = num_in_i;
          num_common_d = num_common_i;
          num_out_d    = num_out_i;
          relu_d       = relu_en_i;
          kt_d         = '0;
          nt_d         = '0;
          w_ptr_d      = ADDR_WIDTH'(FIFO_DEPTH);
          first_d      = 1'b1;
          fill_sent_d  = 1'b0;
          err_d        = 1'b0;
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        tiles_k_d = DATA_WIDTH'(ceil_div(32'(num_common_q), SYS_ROW));
        tiles_n_d = DATA_WIDTH'(ceil_div(32'(num_out_q), SYS_COL));
        if (job_bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_INIT_FILL;
        end
      end
      ST_INIT_FILL: begin
        fill_sent_d = 1'b1;
        if (fill_done_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The weight pointer keeps advancing across column tiles.
        w_ptr_d = w_ptr_q + ADDR_WIDTH'(SYS_COL);
        first_d = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sys_done_i) begin
          w_inv_d = 1'b1;
          if (kt_q == tiles_k_q - DATA_WIDTH'(1)) begin
            kt_d        = '0;
            store_start = 1'b1;
            state_d     = ST_STORE;
          end else begin
            kt_d    = kt_q + DATA_WIDTH'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_STORE: begin
        // Stay one cycle after the last beat so accum_clr precedes the
        // next command or done.
        if (store_last) accum_clr_d = 1'b1;
        if (accum_clr_q) begin
          if (nt_q == tiles_n_q - DATA_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            nt_d    = nt_q + DATA_WIDTH'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      num_in_q     <= '0;
      num_common_q <= '0;
      num_out_q    <= '0;
      relu_q       <= 1'b0;
      tiles_k_q    <= '0;
      tiles_n_q    <= '0;
      kt_q         <= '0;
      nt_q         <= '0;
      w_ptr_q      <= '0;
      first_q      <= 1'b0;
      fill_sent_q  <= 1'b0;
      err_q        <= 1'b0;
      w_inv_q      <= 1'b0;
      accum_clr_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_in_q     <= num_in_d;
      num_common_q <= num_common_d;
      num_out_q    <= num_out_d;
      relu_q       <= relu_d;
      tiles_k_q    <= tiles_k_d;
      tiles_n_q    <= tiles_n_d;
      kt_q         <= kt_d;
      nt_q         <= nt_d;
      w_ptr_q      <= w_ptr_d;
      first_q      <= first_d;
      fill_sent_q  <= fill_sent_d;
      err_q        <= err_d;
      w_inv_q      <= w_inv_d;
      accum_clr_q  <= accum_clr_d;
    end
  end

  tile_store_gen #(
    .ROW_W      (ROW_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (store_start),
    .last_row_i (ROW_W'(num_in_q - DATA_WIDTH'(1))),
    .base_i     (ADDR_WIDTH'(nt_q)),
    .stride_i   (ADDR_WIDTH'(tiles_n_q)),
    .ready_i    (store_ready_i),
    .valid_o    (store_valid_o),
    .row_o      (store_accum_addr_o),
    .addr_o     (store_out_addr_o),
    .last_o     (store_last)
  );

  assign busy_o             = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o             = (state_q == ST_DONE);
  assign err_o              = done_o & err_q;
  assign fill_req_o         = (state_q == ST_INIT_FILL) && !fill_sent_q;
  assign fill_base_o        = '0;
  assign fill_repeat_o      = fill_req_o ? 32'(FILL_REPEAT) : 32'd0;
  assign comp_req_o         = (state_q == ST_ISSUE);
  assign comp_w_base_o      = comp_req_o ? w_ptr_q : '0;
  assign comp_in_base_o     = comp_req_o ? ADDR_WIDTH'(32'(kt_q) * ACCUM_ROW) : '0;
  assign comp_weight_fill_o = comp_req_o & first_q;
  assign w_invalid_o        = {SYS_ROW{w_inv_q}};
  assign store_relu_o       = store_valid_o & relu_q;
  assign accum_clr_o        = accum_clr_q;

endmodule
